// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with a one-byte holding register
//
// Serialises one byte per frame, LSB first, onto an idle-high line.
// A holding register lets the next byte queue while the current frame
// shifts, so back-to-back frames have no idle gap.
//
// Ports:
//   CLK          system clock, rising edge
//   RST_N        asynchronous active-low reset
//   i_TX_DV      byte-valid strobe; accepted when o_TX_Ready is high
//   i_TX_Byte    byte to send, sampled on the accept edge
//   o_TX_Ready   holding register empty
//   o_TX_Active  frame in progress (start, data or stop bit)
//   o_TX_Serial  registered serial line, idle high
//   o_TX_Done    one-cycle pulse in the last clock of each stop bit

module uart_tx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Ready,
    output logic       o_TX_Active,
    output logic       o_TX_Serial,
    output logic       o_TX_Done
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    idx, idx_d;
    logic [7:0]    shift, shift_d;
    logic [7:0]    hold, hold_d;
    logic          hold_valid, hold_valid_d;
    logic          serial_q, serial_d;
    logic          active_q, active_d;
    logic          done_q, done_d;
    logic          count_end;

    assign count_end = (cnt == CNT_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
            serial_q   <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            idx        <= idx_d;
            shift      <= shift_d;
            hold       <= hold_d;
            hold_valid <= hold_valid_d;
            serial_q   <= serial_d;
            active_q   <= active_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        idx_d        = idx;
        shift_d      = shift;
        hold_d       = hold;
        hold_valid_d = hold_valid;
        serial_d     = 1'b1;

        case (state)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (hold_valid) begin
                    shift_d      = hold;
                    hold_valid_d = 1'b0;
                    state_d      = ST_START;
                end
            end
            ST_START: begin
                if (count_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            ST_DATA: begin
                if (count_end) begin
                    cnt_d = '0;
                    if (idx == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx + 3'd1;
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            ST_STOP: begin
                if (count_end) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit when a byte is queued.
                    if (hold_valid) begin
                        shift_d      = hold;
                        hold_valid_d = 1'b0;
                        state_d      = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Accept only into an empty hold; a transfer needs a full hold, so the
        // two never collide on the same edge.
        if (i_TX_DV && !hold_valid) begin
            hold_d       = i_TX_Byte;
            hold_valid_d = 1'b1;
        end

        // Outputs are registered from the next state so they line up with it.
        case (state_d)
            ST_START: serial_d = 1'b0;
            ST_DATA:  serial_d = shift_d[idx_d];
            default:  serial_d = 1'b1;
        endcase
    end

    assign active_d = (state_d != ST_IDLE);
    assign done_d   = (state_d == ST_STOP) && (cnt_d == CNT_LAST);

    assign o_TX_Ready  = !hold_valid;
    assign o_TX_Active = active_q;
    assign o_TX_Serial = serial_q;
    assign o_TX_Done   = done_q;

endmodule
